// File: rtl/lcd_filter_display_if.sv
// lcd_filter_display_if: refresh request, filter index and HD44780 write-only bus.
interface lcd_filter_display_if;
    logic       lcd_reset;
    logic [2:0] filter_number;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       busy;
    modport master (output lcd_reset, filter_number, input lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy);
    modport slave  (input lcd_reset, filter_number, output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy);
endinterface

// File: rtl/lcd_filter_display.sv
// lcd_filter_display: HD44780 16x2 init plus two-line "FILTER n" / name refresh on request.
module lcd_filter_display #(
    parameter int unsigned POWERUP_CYCLES    = 1_000_000,
    parameter int unsigned EN_PULSE_CYCLES   = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2_500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100_000
) (
    input logic clk,
    input logic reset,
    lcd_filter_display_if.slave bus
);
    localparam int unsigned MAX_A = POWERUP_CYCLES > CLEAR_WAIT_CYCLES ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int unsigned MAX_B = EN_PULSE_CYCLES > CMD_WAIT_CYCLES ? EN_PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int unsigned MAXC  = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {POWERUP, INIT, WRITE, IDLE} state_e;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_e;

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d, wait_end;
    logic [5:0]      idx_q, idx_d;
    logic [2:0]      filt_q, filt_d;
    logic            pend_q, pend_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d, en_q, en_d, last, active_d;
    logic [8:0]      byte_d;

    // {rs, data} for write idx of the current pass; INIT and WRITE share one index
    function automatic logic [8:0] bus_byte(input state_e st, input logic [5:0] idx, input logic [2:0] f);
        logic [127:0] l1, l2, sel;
        logic [3:0]   i;
        l1 = {"FILTER ", 5'b00110, f, {8{8'h20}}};
        case (f)
            3'd0:    l2 = {"NONE", {12{8'h20}}};
            3'd1:    l2 = {"GREYSCALE", {7{8'h20}}};
            3'd2:    l2 = {"EDGE DETECT", {5{8'h20}}};
            3'd3:    l2 = {"BLUR", {12{8'h20}}};
            3'd4:    l2 = {"INVERT", {10{8'h20}}};
            default: l2 = {"UNKNOWN", {9{8'h20}}};
        endcase
        sel = idx < 6'd17 ? l1 : l2;
        i   = idx > 6'd17 ? 4'(idx - 6'd18) : 4'(idx - 6'd1);
        if (st == INIT)
            return {1'b0, idx == 6'd0 ? 8'h38 : idx == 6'd1 ? 8'h0C : idx == 6'd2 ? 8'h01 : 8'h06};
        if (idx == 6'd0)
            return 9'h080;
        if (idx == 6'd17)
            return 9'h0C0;
        return {1'b1, 8'(sel >> {4'(4'd15 - i), 3'b000})};
    endfunction

    assign last     = state_q == INIT ? idx_q == 6'd3 : idx_q == 6'd33;
    assign wait_end = (state_q == INIT && idx_q == 6'd2) ? CW'(CLEAR_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        filt_d  = filt_q;
        pend_d  = pend_q | bus.lcd_reset;
        case (state_q)
            POWERUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
                    state_d = INIT;
                    phase_d = SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            IDLE: begin
                if (pend_q) begin
                    pend_d  = bus.lcd_reset;
                    filt_d  = bus.filter_number;
                    state_d = WRITE;
                    phase_d = SETUP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                case (phase_q)
                    SETUP: begin
                        phase_d = PULSE;
                        cnt_d   = '0;
                    end
                    PULSE: begin
                        cnt_d   = cnt_q == CW'(EN_PULSE_CYCLES - 1) ? '0 : cnt_q + 1'b1;
                        phase_d = cnt_q == CW'(EN_PULSE_CYCLES - 1) ? HOLD : PULSE;
                    end
                    default: begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == wait_end) begin
                            cnt_d   = '0;
                            phase_d = SETUP;
                            idx_d   = last ? 6'd0 : idx_q + 6'd1;
                            state_d = !last ? state_q : state_q == INIT ? WRITE : IDLE;
                            filt_d  = (last && state_q == INIT) ? bus.filter_number : filt_q;
                        end
                    end
                endcase
            end
        endcase
        active_d = state_d == INIT || state_d == WRITE;
        byte_d   = bus_byte(state_d, idx_d, filt_d);
        en_d     = active_d && phase_d == PULSE;
        rs_d     = (active_d && phase_d == SETUP) ? byte_d[8] : rs_q;
        data_d   = (active_d && phase_d == SETUP) ? byte_d[7:0] : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= POWERUP;
            phase_q <= SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            filt_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            filt_q  <= filt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
        end
    end

    assign bus.lcd_data = data_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_en   = en_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_on   = 1'b1;
    assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_lcd_filter_display.sv
// tb_lcd_filter_display: directed checks of init, text passes, refresh coalescing and mid-pass reset.
module tb_lcd_filter_display;
    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         w;
        int         rise;
        bit         stable;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel = 0;
    bit   prev_en = 1'b0;
    wr_t  cur;
    wr_t  q[$];

    lcd_filter_display_if bus ();

    lcd_filter_display #(
        .POWERUP_CYCLES(10),
        .EN_PULSE_CYCLES(2),
        .CMD_WAIT_CYCLES(4),
        .CLEAR_WAIT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // capture every strobe: bus value at rise, high time, stability while high
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.lcd_en && !prev_en) begin
            cur.rs = bus.lcd_rs;
            cur.d = bus.lcd_data;
            cur.w = 1;
            cur.rise = cyc;
            cur.stable = 1'b1;
        end else if (bus.lcd_en) begin
            cur.w++;
            if (bus.lcd_rs !== cur.rs || bus.lcd_data !== cur.d) cur.stable = 1'b0;
        end else if (prev_en) begin
            q.push_back(cur);
        end
        prev_en = bus.lcd_en;
    end

    function automatic logic [8:0] exp_w(input int k, input int n);
        string s;
        int i;
        if (k == 0) return 9'h080;
        if (k == 17) return 9'h0C0;
        if (k < 17) s = $sformatf("FILTER %0d", n);
        else case (n)
            0: s = "NONE";
            1: s = "GREYSCALE";
            2: s = "EDGE DETECT";
            3: s = "BLUR";
            4: s = "INVERT";
            default: s = "UNKNOWN";
        endcase
        i = k < 17 ? k - 1 : k - 18;
        return {1'b1, i < s.len() ? 8'(s[i]) : 8'h20};
    endfunction

    task automatic get_writes(input int n, output bit ok);
        int t = 0;
        while (q.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #2;
        ok = q.size() >= n;
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = !bus.busy;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        bus.lcd_reset = 1'b1;
        @(negedge clk);
        bus.lcd_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.lcd_reset = 1'b0;
        bus.filter_number = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus.lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", bus.lcd_data); end
        checks++; if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs got %b expected 0", bus.lcd_rs); end
        checks++; if (bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b expected 0", bus.lcd_rw); end
        checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b expected 0", bus.lcd_en); end
        checks++; if (bus.lcd_on !== 1'b1) begin errors++; $display("FAIL reset_on got %b expected 1", bus.lcd_on); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b expected 1", bus.busy); end
    endtask

    task automatic test_init();
        bit ok;
        logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        @(negedge clk);
        reset = 1'b0;
        rel = cyc + 1;
        get_writes(4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_timeout got %0d writes expected 4", q.size());
            return;
        end
        checks++; if (q[0].rise - rel !== 10) begin errors++; $display("FAIL init_first_rise got cycle %0d expected cycle 11", q[0].rise - rel + 1); end
        checks++; if (q[1].rise - q[0].rise !== 7) begin errors++; $display("FAIL init_cmd_spacing got %0d expected 7", q[1].rise - q[0].rise); end
        checks++; if (q[3].rise - q[2].rise !== 11) begin errors++; $display("FAIL init_clear_spacing got %0d expected 11", q[3].rise - q[2].rise); end
        for (int k = 0; k < 4; k++) begin
            wr_t w = q.pop_front();
            checks++;
            if (w.rs !== 1'b0 || w.d !== cmds[k] || w.w != 2 || !w.stable) begin
                errors++;
                $display("FAIL init_cmd%0d got rs=%b data=%h width=%0d stable=%b expected rs=0 data=%h width=2", k, w.rs, w.d, w.w, w.stable, cmds[k]);
            end
        end
    endtask

    task automatic test_initial_text();
        bit ok;
        get_writes(34, ok);
        checks++; if (!ok) begin errors++; $display("FAIL text0_timeout got %0d writes expected 34", q.size()); return; end
        for (int k = 0; k < 34; k++) begin
            wr_t w = q.pop_front();
            logic [8:0] e = exp_w(k, 0);
            checks++;
            if ({w.rs, w.d} !== e || w.w != 2 || !w.stable) begin
                errors++;
                $display("FAIL text0 write %0d got rs=%b data=%h width=%0d expected rs=%b data=%h width=2", k, w.rs, w.d, w.w, e[8], e[7:0]);
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL text0_busy_fall got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_refresh();
        bit ok;
        @(negedge clk);
        bus.lcd_reset = 1'b1;
        @(negedge clk);
        bus.lcd_reset = 1'b0;
        bus.filter_number = 3'd2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL refresh_latency_early got busy=%b expected 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL refresh_latency got busy=%b expected 1", bus.busy); end
        get_writes(34, ok);
        checks++; if (!ok) begin errors++; $display("FAIL text2_timeout got %0d writes expected 34", q.size()); return; end
        for (int k = 0; k < 34; k++) begin
            wr_t w = q.pop_front();
            logic [8:0] e = exp_w(k, 2);
            checks++;
            if ({w.rs, w.d} !== e || w.w != 2 || !w.stable) begin
                errors++;
                $display("FAIL text2 write %0d got rs=%b data=%h width=%0d expected rs=%b data=%h width=2", k, w.rs, w.d, w.w, e[8], e[7:0]);
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL text2_busy_fall got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_coalesce();
        bit ok;
        bus.filter_number = 3'd3;
        pulse_refresh();
        get_writes(5, ok);
        @(negedge clk);
        bus.filter_number = 3'd1;
        pulse_refresh();
        repeat (20) @(negedge clk);
        bus.filter_number = 3'd5;
        pulse_refresh();
        repeat (20) @(negedge clk);
        bus.lcd_reset = 1'b1;
        @(negedge clk);
        bus.lcd_reset = 1'b0;
        bus.filter_number = 3'd4;
        get_writes(68, ok);
        checks++; if (!ok) begin errors++; $display("FAIL coalesce_timeout got %0d writes expected 68", q.size()); return; end
        for (int k = 0; k < 68; k++) begin
            wr_t w = q.pop_front();
            logic [8:0] e = exp_w(k % 34, k < 34 ? 3 : 4);
            checks++;
            if ({w.rs, w.d} !== e || w.w != 2 || !w.stable) begin
                errors++;
                $display("FAIL coalesce write %0d got rs=%b data=%h width=%0d expected rs=%b data=%h width=2", k, w.rs, w.d, w.w, e[8], e[7:0]);
            end
        end
        wait_idle(ok);
        repeat (300) @(negedge clk);
        checks++;
        if (q.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_extra got %0d extra writes busy=%b expected 0 writes busy=0", q.size(), bus.busy);
        end
    endtask

    task automatic test_unknown();
        bit ok;
        bus.filter_number = 3'd6;
        pulse_refresh();
        get_writes(34, ok);
        checks++; if (!ok) begin errors++; $display("FAIL text6_timeout got %0d writes expected 34", q.size()); return; end
        for (int k = 0; k < 34; k++) begin
            wr_t w = q.pop_front();
            logic [8:0] e = exp_w(k, 6);
            checks++;
            if ({w.rs, w.d} !== e || w.w != 2 || !w.stable) begin
                errors++;
                $display("FAIL text6 write %0d got rs=%b data=%h width=%0d expected rs=%b data=%h width=2", k, w.rs, w.d, w.w, e[8], e[7:0]);
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL text6_busy_fall got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t = 0;
        bus.filter_number = 3'd1;
        pulse_refresh();
        repeat (30) @(negedge clk);
        while (!bus.lcd_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++; if (bus.lcd_en !== 1'b1) begin errors++; $display("FAIL midreset_find_en got en=%b expected 1", bus.lcd_en); end
        reset = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (bus.lcd_en !== 1'b0 || bus.lcd_data !== 8'h00 || bus.lcd_rs !== 1'b0 || bus.busy !== 1'b1 || bus.lcd_on !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs got en=%b data=%h rs=%b busy=%b on=%b expected en=0 data=00 rs=0 busy=1 on=1",
                     bus.lcd_en, bus.lcd_data, bus.lcd_rs, bus.busy, bus.lcd_on);
        end
        @(negedge clk);
        reset = 1'b0;
        rel = cyc + 1;
        q.delete();
        get_writes(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout got %0d writes expected 1", q.size()); return; end
        checks++;
        if (q[0].rs !== 1'b0 || q[0].d !== 8'h38 || q[0].rise - rel != 10) begin
            errors++;
            $display("FAIL midreset_restart got rs=%b data=%h rise cycle %0d expected rs=0 data=38 rise cycle 11",
                     q[0].rs, q[0].d, q[0].rise - rel + 1);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_initial_text();
        test_refresh();
        test_coalesce();
        test_unknown();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
